// File: rtl/ssd_keypad_mux.sv
// Keypad-entry display controller: one digit per press shifts into an N-nibble register, time-multiplexed onto a shared 7-seg bus.
// Entry registers at the accepting edge; seg/dig_sel registered together. Define SSD_BLANK_LEADING_EN to blank digits not yet entered.
module ssd_keypad_mux #(
  parameter int CLK_FREQ   = 125_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int NUM_DIGITS = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              key_pressed,
  input  logic [3:0]                        key_code,
  input  logic                              clear,
  input  logic                              hold,
  output logic [6:0]                        seg,
  output logic [NUM_DIGITS-1:0]             dig_sel,
  output logic [4*NUM_DIGITS-1:0]           value,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   count,
  output logic                              entry_pulse
);

  localparam int DIV_RAW  = CLK_FREQ / (REFRESH_HZ * NUM_DIGITS);
  localparam int TICK_DIV = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW       = $clog2(NUM_DIGITS + 1);
  localparam int VW       = 4 * NUM_DIGITS;

`ifdef SSD_BLANK_LEADING_EN
  localparam logic [6:0] SEG_RST = 7'h00;
`else
  localparam logic [6:0] SEG_RST = 7'h3F;
`endif

  typedef enum logic {IDLE, HELD} state_t;

  state_t                state_q, state_d;
  logic [VW-1:0]         value_q, value_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  pulse_q, pulse_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
  logic [6:0]            seg_q, seg_d;
  logic                  accept;
  logic                  wrap;
  logic [3:0]            nib;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    count_d = count_q;
    // Only the press edge can accept; a press starting under hold/clear is consumed.
    accept  = (state_q == IDLE) && key_pressed && !hold && !clear;
    pulse_d = accept;
    case (state_q)
      IDLE:    if (key_pressed)  state_d = HELD;
      HELD:    if (!key_pressed) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) begin
      value_d = '0;
      count_d = '0;
    end else if (accept) begin
      value_d = (value_q << 4) | VW'(key_code);
      if (count_q != CW'(NUM_DIGITS)) count_d = count_q + 1'b1;
    end
  end

  always_comb begin
    wrap      = (tick_q == TW'(TICK_DIV - 1));
    tick_d    = wrap ? '0 : tick_q + 1'b1;
    idx_d     = idx_q;
    if (wrap) idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    dig_sel_d = NUM_DIGITS'(1) << idx_d;
    // Pattern follows the slot being selected this edge, so select and glyph never disagree.
    nib       = value_q[idx_d*4 +: 4];
    seg_d     = glyph(nib);
`ifdef SSD_BLANK_LEADING_EN
    if (32'(idx_d) >= 32'(count_q)) seg_d = 7'h00;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      value_q   <= '0;
      count_q   <= '0;
      pulse_q   <= 1'b0;
      tick_q    <= '0;
      idx_q     <= '0;
      dig_sel_q <= NUM_DIGITS'(1);
      seg_q     <= SEG_RST;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      count_q   <= count_d;
      pulse_q   <= pulse_d;
      tick_q    <= tick_d;
      idx_q     <= idx_d;
      dig_sel_q <= dig_sel_d;
      seg_q     <= seg_d;
    end
  end

  assign seg         = seg_q;
  assign dig_sel     = dig_sel_q;
  assign value       = value_q;
  assign count       = count_q;
  assign entry_pulse = pulse_q;

endmodule

// File: tb/tb_ssd_keypad_mux.sv
// Scoreboard bench for ssd_keypad_mux: NUM_DIGITS=4, TICK_DIV=4.
module tb_ssd_keypad_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_pressed, clear, hold;
  logic [3:0]  key_code;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;
  logic [15:0] value;
  logic [2:0]  count;
  logic        entry_pulse;

  int checks   = 0;
  int failures = 0;
  int n_pulses = 0;

  typedef struct packed {
    logic [15:0] value;
    logic [2:0]  count;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_value = '0;
  logic [2:0]  m_count = '0;

`ifdef SSD_BLANK_LEADING_EN
  localparam logic [6:0] RST_SEG = 7'h00;
  localparam bit BLANK = 1'b1;
`else
  localparam logic [6:0] RST_SEG = 7'h3F;
  localparam bit BLANK = 1'b0;
`endif

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  ssd_keypad_mux #(.CLK_FREQ(4000), .REFRESH_HZ(250), .NUM_DIGITS(4)) dut (
    .clk(clk), .rst(rst), .key_pressed(key_pressed), .key_code(key_code),
    .clear(clear), .hold(hold), .seg(seg), .dig_sel(dig_sel), .value(value),
    .count(count), .entry_pulse(entry_pulse)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_entry(input logic [3:0] k);
    m_value = {m_value[11:0], k};
    if (m_count != 3'd4) m_count = m_count + 3'd1;
    sb.push_back('{value: m_value, count: m_count});
  endtask

  task automatic press(input logic [3:0] k, input int hi, input int lo, input bit with_hold);
    if (!with_hold) push_entry(k);
    key_code    = k;
    key_pressed = 1'b1;
    hold        = with_hold;
    for (int i = 0; i < hi; i++) begin
      @(negedge clk);
      if (i == hi / 2) hold = 1'b0;
    end
    key_pressed = 1'b0;
    hold        = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear   = 1'b0;
    m_value = '0;
    m_count = '0;
    @(negedge clk);
  endtask

  // Scoreboard consumer: each entry_pulse retires one expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (entry_pulse === 1'b1) begin
        n_pulses++;
        if (sb.size() == 0) check_eq("unexpected_pulse", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          check_eq("entry_value", 32'(value), 32'(e.value));
          check_eq("entry_count", 32'(count), 32'(e.count));
        end
      end
    end
  end

  initial begin
    int p0;
    int w;
    int idx;
    logic [6:0] exp_seg;
    rst = 1'b0; key_pressed = 1'b0; key_code = '0; clear = 1'b0; hold = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_value", 32'(value), 32'h0);
    check_eq("rst_count", 32'(count), 32'h0);
    check_eq("rst_pulse", 32'(entry_pulse), 32'h0);
    check_eq("rst_dig_sel", 32'(dig_sel), 32'h1);
    check_eq("rst_seg", 32'(seg), 32'(RST_SEG));

    rst = 1'b1;
    for (int j = 0; j < 32; j++) begin
      check_eq("refresh_dig_sel", 32'(dig_sel), 32'(4'b0001 << ((j / 4) % 4)));
      check_eq("refresh_seg", 32'(seg), 32'(RST_SEG));
      @(negedge clk);
    end

    p0 = n_pulses;
    for (int k = 1; k <= 5; k++) press(4'(k), 10, 5, 1'b0);
    check_eq("shift_value", 32'(value), 32'h2345);
    check_eq("shift_count", 32'(count), 32'd4);
    check_eq("shift_pulses", 32'(n_pulses - p0), 32'd5);

    do_clear();
    check_eq("clear_value", 32'(value), 32'h0);
    p0 = n_pulses;
    press(4'h7, 100, 5, 1'b0);
    check_eq("longhold_value", 32'(value), 32'h0007);
    check_eq("longhold_count", 32'(count), 32'd1);
    check_eq("longhold_pulses", 32'(n_pulses - p0), 32'd1);

    p0 = n_pulses;
    press(4'h9, 10, 5, 1'b1);
    check_eq("hold_value", 32'(value), 32'h0007);
    check_eq("hold_pulses", 32'(n_pulses - p0), 32'd0);

    key_code = 4'h6; key_pressed = 1'b1; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; m_value = '0; m_count = '0;
    repeat (5) @(negedge clk);
    key_pressed = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("clrpress_value", 32'(value), 32'h0);
    check_eq("clrpress_count", 32'(count), 32'h0);
    check_eq("clrpress_pulses", 32'(n_pulses - p0), 32'd0);

    press(4'h3, 6, 5, 1'b0);
    press(4'hA, 6, 20, 1'b0);
    for (int j = 0; j < 16; j++) begin
      check_eq("disp_onehot", 32'($onehot(dig_sel)), 32'd1);
      idx = 0;
      for (int b = 0; b < 4; b++) if (dig_sel[b]) idx = b;
      exp_seg = glyph_tab[m_value[idx*4 +: 4]];
      if (BLANK && idx >= int'(m_count)) exp_seg = 7'h00;
      check_eq("disp_seg", 32'(seg), 32'(exp_seg));
      @(negedge clk);
    end

    w = 0;
    while (dig_sel !== 4'b0100 && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (w >= 40) check_eq("wait_idx2", 32'd0, 32'd1);
    #2 rst = 1'b0;
    key_code = 4'hC; key_pressed = 1'b1;
    #1;
    check_eq("async_value", 32'(value), 32'h0);
    check_eq("async_count", 32'(count), 32'h0);
    check_eq("async_pulse", 32'(entry_pulse), 32'h0);
    check_eq("async_dig_sel", 32'(dig_sel), 32'h1);
    check_eq("async_seg", 32'(seg), 32'(RST_SEG));
    m_value = '0; m_count = '0;
    p0 = n_pulses;
    push_entry(4'hC);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    key_pressed = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("async_entry_pulses", 32'(n_pulses - p0), 32'd1);
    check_eq("async_entry_value", 32'(value), 32'h000C);
    check_eq("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
